// File: rtl/julia_iterator.sv
// Fixed-point Julia-set escape-time iterator: one z <- z^2 + c step per clock,
// with a valid/ready request side, a held result side and synchronous abort.
module julia_iterator #(
  parameter int WIDTH      = 22,
  parameter int FRACTIONAL = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] z0_real,
  input  logic signed [WIDTH-1:0] z0_imag,
  input  logic signed [WIDTH-1:0] c_real,
  input  logic signed [WIDTH-1:0] c_imag,
  input  logic        [7:0]       max_iter,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [7:0]       out_iter,
  output logic                    out_escaped
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = 2 * WIDTH + 1;
  // |z|^2 >= 4.0, expressed in the squared (2*FRACTIONAL) fixed-point scale
  localparam logic signed [MW-1:0] ESC_LIMIT = MW'(4) <<< (2 * FRACTIONAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_zr;
  logic signed [WIDTH-1:0] r_zi;
  logic signed [WIDTH-1:0] r_cr;
  logic signed [WIDTH-1:0] r_ci;
  logic        [7:0]       r_n;
  logic        [7:0]       r_max;
  logic                    r_out_valid;
  logic        [7:0]       r_out_iter;
  logic                    r_out_escaped;

  logic signed [PW-1:0]    w_zr_ext;
  logic signed [PW-1:0]    w_zi_ext;
  logic signed [PW-1:0]    w_p_rr;
  logic signed [PW-1:0]    w_p_ii;
  logic signed [PW-1:0]    w_p_ri;
  logic signed [MW-1:0]    w_p_ri2;
  logic signed [MW-1:0]    w_mag2;
  logic signed [WIDTH-1:0] w_sq_r;
  logic signed [WIDTH-1:0] w_sq_i;
  logic signed [WIDTH-1:0] w_cross;
  logic signed [WIDTH-1:0] w_zr_next;
  logic signed [WIDTH-1:0] w_zi_next;
  logic                    w_escape;
  logic                    w_limit;

  assign w_zr_ext = PW'(r_zr);
  assign w_zi_ext = PW'(r_zi);
  assign w_p_rr   = w_zr_ext * w_zr_ext;
  assign w_p_ii   = w_zi_ext * w_zi_ext;
  assign w_p_ri   = w_zr_ext * w_zi_ext;

  // The escape test uses the exact squared magnitude; the doubling of the
  // cross term happens before the rescale so no fraction bit is lost.
  assign w_mag2   = MW'(w_p_rr) + MW'(w_p_ii);
  assign w_p_ri2  = MW'(w_p_ri) <<< 1;

  assign w_sq_r    = WIDTH'(w_p_rr >>> FRACTIONAL);
  assign w_sq_i    = WIDTH'(w_p_ii >>> FRACTIONAL);
  assign w_cross   = WIDTH'(w_p_ri2 >>> FRACTIONAL);
  assign w_zr_next = w_sq_r - w_sq_i + r_cr;
  assign w_zi_next = w_cross + r_ci;

  assign w_escape = (w_mag2 >= ESC_LIMIT);
  assign w_limit  = (r_n == r_max);

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_escaped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_zr          <= '0;
      r_zi          <= '0;
      r_cr          <= '0;
      r_ci          <= '0;
      r_n           <= '0;
      r_max         <= '0;
      r_out_valid   <= 1'b0;
      r_out_iter    <= '0;
      r_out_escaped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_zr    <= z0_real;
            r_zi    <= z0_imag;
            r_cr    <= c_real;
            r_ci    <= c_imag;
            r_max   <= max_iter;
            r_n     <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          // Abort wins over termination; escape wins over the iteration limit
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_escape || w_limit) begin
            r_out_iter    <= r_n;
            r_out_escaped <= w_escape;
            r_out_valid   <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_zr <= w_zr_next;
            r_zi <= w_zi_next;
            r_n  <= r_n + 8'd1;
          end
        end
        S_DONE: begin
          if (abort || out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_julia_iterator.sv
// Directed bench for julia_iterator: an escape-time reference model plus a
// latency/handshake model checked on every falling edge, and literal vectors.
module tb_julia_iterator;

  localparam int W = 22;
  localparam int F = 11;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] z0_real = '0;
  logic signed [W-1:0] z0_imag = '0;
  logic signed [W-1:0] c_real = '0;
  logic signed [W-1:0] c_imag = '0;
  logic        [7:0]   max_iter = '0;
  logic                abort = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic        [7:0]   out_iter;
  logic                out_escaped;

  int checks = 0;
  int errors = 0;

  // Model state: edges remaining until the result appears, and the held result
  int         m_cnt = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_iter = '0;
  logic       m_esc = 1'b0;
  logic [8:0] m_pred;

  julia_iterator #(.WIDTH(W), .FRACTIONAL(F)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .z0_real     (z0_real),
    .z0_imag     (z0_imag),
    .c_real      (c_real),
    .c_imag      (c_imag),
    .max_iter    (max_iter),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped)
  );

  always #5 clk = ~clk;

  function automatic longint wrapW(input longint x);
    logic [W-1:0] t;
    t = x[W-1:0];
    return longint'(signed'(t));
  endfunction

  // Whole-job escape-time result as {escaped, iterations}
  function automatic logic [8:0] juliaModel(input longint zr0, input longint zi0,
                                            input longint cr, input longint ci,
                                            input int maxi);
    longint zr;
    longint zi;
    longint nr;
    longint ni;
    zr = zr0;
    zi = zi0;
    for (int n = 0; n <= 255; n++) begin
      if (zr * zr + zi * zi >= (longint'(4) << (2 * F))) return {1'b1, 8'(n)};
      if (n == maxi) return {1'b0, 8'(n)};
      nr = wrapW(wrapW((zr * zr) >>> F) - wrapW((zi * zi) >>> F) + cr);
      ni = wrapW(wrapW((2 * zr * zi) >>> F) + ci);
      zr = nr;
      zi = ni;
    end
    return 9'h1FF;
  endfunction

  always_comb m_pred = juliaModel(longint'(z0_real), longint'(z0_imag),
                                  longint'(c_real), longint'(c_imag), int'(max_iter));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Job timing: a result with count k appears k+1 edges after acceptance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
    end else if (m_valid) begin
      if (abort || out_ready) m_valid <= 1'b0;
    end else if (m_cnt > 0) begin
      if (abort) begin
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_valid <= 1'b1;
      end
    end else if (in_valid) begin
      m_iter <= m_pred[7:0];
      m_esc  <= m_pred[8];
      m_cnt  <= int'(m_pred[7:0]) + 1;
    end
  end

  always @(negedge clk) begin
    checkOutput("cyc in_ready", int'(in_ready), int'(m_cnt == 0 && !m_valid));
    checkOutput("cyc out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      checkOutput("cyc out_iter", int'(out_iter), int'(m_iter));
      checkOutput("cyc out_escaped", int'(out_escaped), int'(m_esc));
    end
  end

  task automatic startJob(input logic signed [W-1:0] zr, input logic signed [W-1:0] zi,
                          input logic signed [W-1:0] cr, input logic signed [W-1:0] ci,
                          input logic [7:0] mi);
    @(negedge clk);
    in_valid = 1'b1;
    z0_real  = zr;
    z0_imag  = zi;
    c_real   = cr;
    c_imag   = ci;
    max_iter = mi;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    z0_real  = 22'sh155555;
    z0_imag  = 22'sh0AAAAA;
    c_real   = 22'sh123456;
    c_imag   = 22'sh054321;
    max_iter = 8'hA5;
  endtask

  task automatic waitResult(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!out_valid && edges < 400);
  endtask

  task automatic consumeResult(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, " consumed"}, int'(out_valid), 0);
  endtask

  task automatic applyStimulus(input logic signed [W-1:0] zr, input logic signed [W-1:0] zi,
                               input logic signed [W-1:0] cr, input logic signed [W-1:0] ci,
                               input logic [7:0] mi, input int expIter, input int expEsc,
                               input int expLat, input int stall, input string name);
    int edges;
    startJob(zr, zi, cr, ci, mi);
    waitResult(edges);
    checkOutput({name, " latency"}, edges, expLat);
    checkOutput({name, " out_iter"}, int'(out_iter), expIter);
    checkOutput({name, " out_escaped"}, int'(out_escaped), expEsc);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({name, " stall out_valid"}, int'(out_valid), 1);
      checkOutput({name, " stall out_iter"}, int'(out_iter), expIter);
      checkOutput({name, " stall out_escaped"}, int'(out_escaped), expEsc);
      checkOutput({name, " stall in_ready"}, int'(in_ready), 0);
    end
  endtask

  task automatic runModelOnly(input logic signed [W-1:0] zr, input logic signed [W-1:0] zi,
                              input logic signed [W-1:0] cr, input logic signed [W-1:0] ci,
                              input logic [7:0] mi, input string name);
    int edges;
    startJob(zr, zi, cr, ci, mi);
    waitResult(edges);
    checkOutput({name, " completed"}, int'(out_valid), 1);
    consumeResult(name);
  endtask

  initial begin
    int seen;

    #1;
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_iter", int'(out_iter), 0);
    checkOutput("reset out_escaped", int'(out_escaped), 0);

    // Literal pins on the reference model itself
    checkOutput("model origin", int'(juliaModel(0, 0, 0, 0, 255)), 255);
    checkOutput("model z=2", int'(juliaModel(4096, 0, 0, 0, 255)), 256);
    checkOutput("model c=1", int'(juliaModel(0, 0, 2048, 0, 255)), 256 + 2);
    checkOutput("model c=-1", int'(juliaModel(0, 0, -2048, 0, 20)), 20);
    checkOutput("model c=i", int'(juliaModel(0, 0, 0, 2048, 30)), 30);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 0, 8'd255, 255, 0, 256, 0, "origin");
    consumeResult("origin");
    applyStimulus(22'sh001000, 0, 0, 0, 8'd255, 0, 1, 1, 0, "z=2");
    consumeResult("z=2");
    applyStimulus(-22'sd4096, 0, 0, 0, 8'd255, 0, 1, 1, 0, "z=-2");
    consumeResult("z=-2");
    applyStimulus(22'sh000C00, 22'sh000C00, 0, 0, 8'd255, 0, 1, 1, 0, "z=1.5+1.5i");
    consumeResult("z=1.5+1.5i");
    applyStimulus(0, 0, 0, 0, 8'd0, 0, 0, 1, 0, "max0");
    consumeResult("max0");
    applyStimulus(0, 0, 0, 22'sh000800, 8'd30, 30, 0, 31, 0, "c=i");
    consumeResult("c=i");

    // c=1 held for ten cycles, then consumed with the next request already waiting
    applyStimulus(0, 0, 22'sh000800, 0, 8'd255, 2, 1, 3, 10, "c=1 stall");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    z0_real   = 22'sh001000;
    z0_imag   = '0;
    c_real    = '0;
    c_imag    = '0;
    max_iter  = 8'd255;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("no accept on consume edge", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("accept after consume", int'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("follow-on out_valid", int'(out_valid), 1);
    checkOutput("follow-on out_iter", int'(out_iter), 0);
    checkOutput("follow-on out_escaped", int'(out_escaped), 1);
    consumeResult("follow-on");

    applyStimulus(0, 0, -22'sd2048, 0, 8'd20, 20, 0, 21, 0, "c=-1");
    consumeResult("c=-1");

    // Reset in the middle of a job clears the held result and discards the job
    startJob(0, 0, 0, 0, 8'd50);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-job rst out_valid", int'(out_valid), 0);
    checkOutput("mid-job rst out_iter", int'(out_iter), 0);
    checkOutput("mid-job rst out_escaped", int'(out_escaped), 0);
    checkOutput("mid-job rst in_ready", int'(in_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("no result after rst", seen, 0);

    // Abort during the fifth iteration cycle of the long origin job
    startJob(0, 0, 0, 0, 8'd255);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("no result after abort", seen, 0);

    // Abort is ignored in idle, and beats out_ready while a result is held
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    z0_real  = 22'sh001000;
    z0_imag  = '0;
    c_real   = '0;
    c_imag   = '0;
    max_iter = 8'd255;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    checkOutput("idle abort accepted", int'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle abort result", int'(out_valid), 1);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b0;
    checkOutput("done abort out_valid", int'(out_valid), 0);
    checkOutput("done abort in_ready", int'(in_ready), 1);

    runModelOnly(0, 0, -22'sd1526, 22'sh0001A0, 8'd255, "frac a");
    runModelOnly(22'sh000300, -22'sd400, 22'sh000200, 22'sh000480, 8'd100, "frac b");
    runModelOnly(-22'sd900, 22'sh000150, 22'sh1F0000, -22'sd300000, 8'd255, "large c");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/julia_iterator.md
JULIA_ITERATOR -- requirements
Module: julia_iterator

Interface
REQ-001 Parameter WIDTH, 22, signed fixed-point word width of all z/c values.
REQ-002 Parameter FRACTIONAL, 11, fractional bits; 1.0 = 2^FRACTIONAL (0x800).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present on z0_*/c_*/max_iter.
REQ-006 in_ready  output  1  block can accept a request; high exactly when state is IDLE.
REQ-007 z0_real, z0_imag  input  WIDTH each  signed starting z (pixel coordinate).
REQ-008 c_real, c_imag  input  WIDTH each  signed Julia constant c.
REQ-009 max_iter  input  8  unsigned iteration limit.
REQ-010 abort  input  1  synchronous cancel of the current job.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_iter  output  8  unsigned iteration count of the result.
REQ-014 out_escaped  output  1  1 = |z|^2 reached 4.0; 0 = limit reached first.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ITER, DONE.
REQ-016 IDLE: on in_valid & in_ready, the block SHALL latch z0 into z, latch c and max_iter, clear iteration count n to 0, and enter ITER.
REQ-017 ITER, each cycle: the block SHALL compute mag2 = zr*zr + zi*zi at full 2*WIDTH+1 precision, no truncation and no wrap.
REQ-018 ITER: if mag2 >= 4 * 2^(2*FRACTIONAL), the block SHALL load out_iter = n and out_escaped = 1, then enter DONE.
REQ-019 ITER: else if n == max_iter, the block SHALL load out_iter = n and out_escaped = 0, then enter DONE; escape takes priority when both conditions hold.
REQ-020 ITER: otherwise the block SHALL update zr <= zr^2 - zi^2 + cr and zi <= 2*zr*zi + ci, and set n <= n + 1.
REQ-021 Each product SHALL be the full signed product arithmetically shifted right by FRACTIONAL, then truncated to WIDTH bits.
REQ-022 All WIDTH-bit additions and subtractions SHALL wrap (two's complement); no saturation.
REQ-023 Latency: if the job ends with out_iter = k, out_valid SHALL rise k+1 clock edges after the accepting edge.
REQ-024 DONE: out_valid SHALL be 1, and out_iter and out_escaped SHALL hold stable until out_ready is sampled high.
REQ-025 DONE: on out_ready, the block SHALL return to IDLE; the next request SHALL NOT be accepted on that same edge.
REQ-026 abort high in ITER or DONE SHALL force IDLE on the next edge with no result produced; abort in IDLE SHALL have no effect.
REQ-027 abort SHALL take priority over a simultaneous termination or out_ready.
REQ-028 n SHALL never exceed max_iter, so n cannot wrap.
REQ-029 With max_iter = 0, the job SHALL terminate in its first ITER cycle.
REQ-030 in_valid while not in IDLE SHALL be ignored, and inputs SHALL be sampled only on the accepting edge.

Reset
REQ-031 rst SHALL immediately (asynchronously) force state IDLE, out_valid 0, out_iter 0, out_escaped 0, and clear z, c, n and max_iter.
REQ-032 in_ready SHALL be 1 while rst is high and after its release.
REQ-033 rst during ITER or DONE SHALL discard the job; no out_valid pulse SHALL follow reset release.

Verification
REQ-034 z0=(0,0), c=(0,0), max_iter=255 -> out_iter=255, out_escaped=0, out_valid 256 edges after accept.
REQ-035 z0=(0x1000,0) (=2.0), c=0, max_iter=255 -> out_iter=0, out_escaped=1, out_valid 1 edge after accept.
REQ-036 z0=0, c=(0x800,0), max_iter=255 -> z sequence 0,1,2 -> out_iter=2, out_escaped=1, out_valid 3 edges after accept.
REQ-037 Scenario REQ-036 with out_ready=0 for 10 cycles -> out_valid and outputs stable and in_ready=0 throughout; the result is consumed on the first out_ready edge, and the next request is accepted one edge later.
REQ-038 z0=0, c=0, max_iter=0 -> out_iter=0, out_escaped=0 after 1 edge; the same job with max_iter=50 and rst asserted at cycle 20 -> outputs 0 immediately and no result after release.
REQ-039 abort asserted in ITER cycle 5 of scenario REQ-034 -> IDLE next edge, in_ready=1, and out_valid never rises.
